data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_if.sv | 28 ++
 rtl/data_mem.sv | 33 +++
 tb/tb_data_mem.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Port bundle for the simple dual-port data memory.
// The master drives the write port and the read address; the slave returns registered read data.
interface data_mem_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;

    modport master (
        output addra,
        output dina,
        output wea,
        output addrb,
        input  doutb
    );

    modport slave (
        input  addra,
        input  dina,
        input  wea,
        input  addrb,
        output doutb
    );
endinterface

// File: rtl/data_mem.sv
// Simple dual-port block RAM: port A writes only, port B reads only, with a registered read output.
// Reset clears the output register and blocks writes, but it never clears the array contents.
module data_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    data_mem_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The zero initialiser becomes the RAM configuration image, so words that are never written read as 0.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    // The write port has no reset branch, which keeps it inferable as block RAM.
    // rst_n acts as a synchronous write gate here, so writes are ignored while reset is low.
    always_ff @(posedge clk) begin
        if (rst_n && bus.wea) begin
            mem[bus.addra] <= bus.dina;
        end
    end

    // The output register samples the array on every edge, which gives read-first behaviour on collisions.
    // Its asynchronous clear zeroes doutb as soon as reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.doutb <= '0;
        end else begin
            bus.doutb <= mem[bus.addrb];
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem.
// Each check compares doutb with a hand-computed value.
module tb_data_mem;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    data_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    data_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for a rising edge, then move 1 time unit past it. Inputs change and outputs are sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [DW-1:0] observed,
                                input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic w, input logic [AW-1:0] wa,
                                  input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        bus.wea   = w;
        bus.addra = wa;
        bus.dina  = wd;
        bus.addrb = ra;
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        apply_stimulus(1'b0, '0, '0, '0);
        #3;
        check_output("reset_doutb", bus.doutb, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Power-up read of a word that was never written
        apply_stimulus(1'b0, '0, '0, 10'h005);
        step();
        check_output("powerup_0x005", bus.doutb, 32'h0);

        // Write, then read in the next cycle
        apply_stimulus(1'b1, 10'h010, 32'hDEADBEEF, 10'h005);
        step();
        apply_stimulus(1'b0, '0, '0, 10'h010);
        step();
        check_output("write_read_0x010", bus.doutb, 32'hDEADBEEF);
        #3;
        check_output("hold_between_edges", bus.doutb, 32'hDEADBEEF);

        // wea=0 must not modify the array
        step();
        apply_stimulus(1'b0, 10'h010, 32'hFFFFFFFF, 10'h005);
        step();
        apply_stimulus(1'b0, '0, '0, 10'h010);
        step();
        check_output("wea0_no_write", bus.doutb, 32'hDEADBEEF);

        // Read-first collision
        apply_stimulus(1'b1, 10'h020, 32'h11111111, 10'h005);
        step();
        apply_stimulus(1'b1, 10'h020, 32'h22222222, 10'h020);
        step();
        check_output("collision_old", bus.doutb, 32'h11111111);
        apply_stimulus(1'b0, '0, '0, 10'h020);
        step();
        check_output("collision_new", bus.doutb, 32'h22222222);

        // Both ports active at once on different addresses, including the top address
        apply_stimulus(1'b1, 10'h000, 32'h12345678, 10'h005);
        step();
        apply_stimulus(1'b1, 10'h3FF, 32'hA5A5A5A5, 10'h000);
        step();
        check_output("indep_read_0x000", bus.doutb, 32'h12345678);
        apply_stimulus(1'b0, '0, '0, 10'h3FF);
        step();
        check_output("read_0x3FF", bus.doutb, 32'hA5A5A5A5);
        apply_stimulus(1'b0, '0, '0, 10'h1FF);
        step();
        check_output("no_alias_0x1FF", bus.doutb, 32'h0);

        // Back-to-back writes to one address keep the last value
        apply_stimulus(1'b1, 10'h030, 32'h00000001, 10'h005);
        step();
        apply_stimulus(1'b1, 10'h030, 32'h00000002, 10'h005);
        step();
        apply_stimulus(1'b0, '0, '0, 10'h030);
        step();
        check_output("last_write_wins", bus.doutb, 32'h00000002);

        // Assert reset mid-operation
        apply_stimulus(1'b0, '0, '0, 10'h010);
        step();
        check_output("pre_reset_0x010", bus.doutb, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset_clear", bus.doutb, 32'h0);
        apply_stimulus(1'b1, 10'h010, 32'h0, 10'h010);
        step();
        check_output("reset_holds_zero", bus.doutb, 32'h0);
        apply_stimulus(1'b0, '0, '0, 10'h010);
        rst_n = 1'b1;
        step();
        check_output("write_suppressed_in_reset", bus.doutb, 32'hDEADBEEF);

        // A write just before reset must survive the reset
        apply_stimulus(1'b1, 10'h040, 32'hCAFEF00D, 10'h005);
        step();
        apply_stimulus(1'b0, '0, '0, 10'h040);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_output("write_survives_reset", bus.doutb, 32'hCAFEF00D);

        // Streaming reads: k+100 is written to address k
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1, AW'(k), DW'(k + 100), 10'h005);
            step();
        end
        bus.wea = 1'b0;
        apply_stimulus(1'b0, '0, '0, 10'h000);
        step();
        check_output("stream_0", bus.doutb, 32'd100);
        apply_stimulus(1'b0, '0, '0, 10'h001);
        step();
        check_output("stream_1", bus.doutb, 32'd101);
        apply_stimulus(1'b0, '0, '0, 10'h002);
        step();
        check_output("stream_2", bus.doutb, 32'd102);
        apply_stimulus(1'b0, '0, '0, 10'h003);
        step();
        check_output("stream_3", bus.doutb, 32'd103);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
